// File: rtl/slice_mem_pkg.sv
`default_nettype none
// ============================================================================
// slice_mem_pkg : shared types and helpers for the multi-channel slice MAC
// Rev 1.0
// ============================================================================
package slice_mem_pkg;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  localparam int DWIDTH_DEF = 8;
  localparam int CWIDTH_DEF = 9;
  localparam int WPI_DEF    = 40;
  localparam int SAT_W      = 64;

  typedef struct packed {
    logic                    ovf;
    logic signed [SAT_W-1:0] val;
  } sat_t;

  // Counter/pointer width that stays legal for a depth of 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Signed coefficient times zero-extended pixel needs one extra bit.
  function automatic int prod_width(input int cw, input int dw);
    return cw + dw + 1;
  endfunction

  // Operands arrive sign-extended from w bits; result clamps to the w-bit range.
  function automatic sat_t sat_add(input logic signed [SAT_W-1:0] a,
                                   input logic signed [SAT_W-1:0] b,
                                   input int                      w);
    logic signed [SAT_W:0] sum;
    logic signed [SAT_W:0] hi;
    logic signed [SAT_W:0] lo;
    sat_t                  r;
    sum   = {a[SAT_W-1], a} + {b[SAT_W-1], b};
    hi    = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo    = -(65'sd1 <<< (w - 1));
    r.ovf = 1'b0;
    r.val = sum[SAT_W-1:0];
    if (sum > hi) begin
      r.ovf = 1'b1;
      r.val = hi[SAT_W-1:0];
    end else if (sum < lo) begin
      r.ovf = 1'b1;
      r.val = lo[SAT_W-1:0];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/slice_linebuf.sv
`default_nettype none
// ============================================================================
// slice_linebuf : circular line buffer of window partial sums, zero until written
// Rev 1.0
// ============================================================================
module slice_linebuf
  import slice_mem_pkg::*;
#(
  parameter  int DEPTH = 40,
  parameter  int WIDTH = 64,
  localparam int AW    = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clken_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             flush_i,
  input  logic [AW-1:0]    flush_addr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [AW-1:0]    ptr_q;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;

  assign wr_en   = clken_i | flush_i;
  assign wr_addr = flush_i ? flush_addr_i : ptr_q;
  assign wr_data = flush_i ? '0 : wdata_i;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // The valid vector, not the RAM, carries reset so the array stays inferable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      ptr_q   <= '0;
    end else if (flush_i) begin
      valid_q[flush_addr_i] <= 1'b0;
      ptr_q                 <= '0;
    end else if (clken_i) begin
      valid_q[ptr_q] <= 1'b1;
      ptr_q          <= (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
    end
  end

  // The slot at ptr holds the commit made DEPTH commits ago.
  assign rdata_o = valid_q[ptr_q] ? mem_q[ptr_q] : '0;

endmodule
`default_nettype wire

// File: rtl/slice_mem_mc.sv
`default_nettype none
// ============================================================================
// slice_mem_mc : multi-channel windowed pixel x coefficient accumulator with
//                line-buffer recall; SLICE_MEM_MC_SAT_EN adds saturation + ovf
// Rev 1.0
// ============================================================================
module slice_mem_mc
  import slice_mem_pkg::*;
#(
  parameter int DWIDTH    = DWIDTH_DEF,
  parameter int CWIDTH    = CWIDTH_DEF,
  parameter int AWIDTH    = 32,
  parameter int NCH       = 2,
  parameter int BLOCKSIZE = 32,
  parameter int WINCOLS   = 8,
  parameter int WPI       = WPI_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  dvi,
  input  logic [DWIDTH-1:0]     data,
  input  logic [NCH*CWIDTH-1:0] svcoeff,
  input  logic                  download,
  output logic                  busy,
  output logic                  dvo,
  output logic [NCH*AWIDTH-1:0] regout,
  output logic [NCH-1:0]        msb
`ifdef SLICE_MEM_MC_SAT_EN
  ,
  output logic [NCH-1:0]        ovf
`endif
);

  localparam int PWIDTH = prod_width(CWIDTH, DWIDTH);
  localparam int PCW    = cnt_width(BLOCKSIZE);
  localparam int BCW    = cnt_width(WINCOLS);
  localparam int PTRW   = cnt_width(WPI);
  localparam logic [PCW-1:0]  PIX_LAST = PCW'(BLOCKSIZE - 1);
  localparam logic [BCW-1:0]  BLK_LAST = BCW'(WINCOLS - 1);
  localparam logic [PTRW-1:0] FL_LAST  = PTRW'(WPI - 1);

  state_e                state_q, state_d;
  logic [PTRW-1:0]       flcnt_q, flcnt_d;
  logic                  adv, clr, lb_flush;
  logic [PCW-1:0]        pixcnt_q;
  logic [BCW-1:0]        blockcnt_q;
  logic                  newblock, newwin, commit;
  logic                  newwin_d_q, newwin_d2_q, dvo_q;
  logic [NCH*AWIDTH-1:0] lb_wdata, lb_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      flcnt_q <= '0;
    end else begin
      state_q <= state_d;
      flcnt_q <= flcnt_d;
    end
  end

  // download beats a coincident dvi; a held download keeps restarting the clear.
  always_comb begin
    state_d  = state_q;
    flcnt_d  = flcnt_q;
    busy     = 1'b0;
    lb_flush = 1'b0;
    clr      = 1'b0;
    adv      = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (download) begin
          state_d = ST_FLUSH;
          flcnt_d = '0;
          clr     = 1'b1;
        end else begin
          adv = dvi;
        end
      end
      ST_FLUSH: begin
        busy     = 1'b1;
        lb_flush = 1'b1;
        if (download) begin
          flcnt_d = '0;
        end else if (flcnt_q == FL_LAST) begin
          state_d = ST_RUN;
          flcnt_d = '0;
        end else begin
          flcnt_d = flcnt_q + PTRW'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign newblock = adv & (pixcnt_q == PIX_LAST);
  assign newwin   = newblock & (blockcnt_q == BLK_LAST);
  assign commit   = adv & newwin_d_q;
  assign dvo      = dvo_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pixcnt_q    <= '0;
      blockcnt_q  <= '0;
      newwin_d_q  <= 1'b0;
      newwin_d2_q <= 1'b0;
      dvo_q       <= 1'b0;
    end else begin
      dvo_q <= commit;
      if (clr) begin
        pixcnt_q    <= '0;
        blockcnt_q  <= '0;
        newwin_d_q  <= 1'b0;
        newwin_d2_q <= 1'b0;
      end else if (adv) begin
        pixcnt_q    <= (pixcnt_q == PIX_LAST) ? '0 : pixcnt_q + PCW'(1);
        newwin_d_q  <= newwin;
        newwin_d2_q <= newwin_d_q;
        if (newblock)
          blockcnt_q <= (blockcnt_q == BLK_LAST) ? '0 : blockcnt_q + BCW'(1);
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic signed [CWIDTH-1:0] coef;
    logic signed [PWIDTH-1:0] prod;
    logic signed [AWIDTH-1:0] mult_q, tmp_q, regout_q;
    logic signed [AWIDTH-1:0] fifo_out, base, tmp_sum, shift_sum;
    logic                     msb_q;

    assign coef     = signed'(svcoeff[c*CWIDTH +: CWIDTH]);
    assign prod     = PWIDTH'(coef) * signed'(PWIDTH'({1'b0, data}));
    assign fifo_out = signed'(lb_rdata[c*AWIDTH +: AWIDTH]);
    // First pixel product of a new window is seeded with last row's partial sum.
    assign base     = newwin_d2_q ? fifo_out : tmp_q;

`ifdef SLICE_MEM_MC_SAT_EN
    sat_t tmp_sat, shift_sat;
    logic ovf_q;
    assign tmp_sat   = sat_add(SAT_W'(base), SAT_W'(mult_q), AWIDTH);
    assign shift_sat = sat_add(SAT_W'(tmp_q), SAT_W'(mult_q), AWIDTH);
    assign tmp_sum   = tmp_sat.val[AWIDTH-1:0];
    assign shift_sum = shift_sat.val[AWIDTH-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
        ovf_q <= 1'b0;
      else if (clr)
        ovf_q <= 1'b0;
      else if (adv & (tmp_sat.ovf | (commit & shift_sat.ovf)))
        ovf_q <= 1'b1;
    end
    assign ovf[c] = ovf_q;
`else
    assign tmp_sum   = base + mult_q;
    assign shift_sum = tmp_q + mult_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        mult_q   <= '0;
        tmp_q    <= '0;
        regout_q <= '0;
        msb_q    <= 1'b0;
      end else if (clr) begin
        mult_q   <= '0;
        tmp_q    <= '0;
        regout_q <= '0;
        msb_q    <= 1'b0;
      end else if (adv) begin
        mult_q <= AWIDTH'(prod);
        tmp_q  <= tmp_sum;
        if (commit) begin
          regout_q <= shift_sum;
          msb_q    <= ~shift_sum[AWIDTH-1] & (|shift_sum);
        end
      end
    end

    assign lb_wdata[c*AWIDTH +: AWIDTH] = shift_sum;
    assign regout[c*AWIDTH +: AWIDTH]   = regout_q;
    assign msb[c]                       = msb_q;
  end

  slice_linebuf #(
    .DEPTH (WPI),
    .WIDTH (NCH * AWIDTH)
  ) u_linebuf (
    .clk          (clk),
    .reset_n      (reset_n),
    .clken_i      (commit),
    .wdata_i      (lb_wdata),
    .flush_i      (lb_flush),
    .flush_addr_i (flcnt_q),
    .rdata_o      (lb_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_slice_mem_mc.sv
`default_nettype none
// ============================================================================
// tb_slice_mem_mc : directed scoreboard bench for slice_mem_mc
// Rev 1.0
// ============================================================================
module tb_slice_mem_mc;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dvi, download;
  logic [7:0]  data;
  logic [17:0] svcoeff;
  logic        busy, dvo;
  logic [63:0] regout;
  logic [1:0]  msb;

  logic        dvi2, download2;
  logic [7:0]  data2;
  logic [17:0] svcoeff2;
  logic        busy2, dvo2;
  logic [35:0] regout2;
  logic [1:0]  msb2;
`ifdef SLICE_MEM_MC_SAT_EN
  logic [1:0]  ovf, ovf2;
`endif

  slice_mem_mc #(
    .DWIDTH(8), .CWIDTH(9), .AWIDTH(32), .NCH(2),
    .BLOCKSIZE(2), .WINCOLS(2), .WPI(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .dvi(dvi), .data(data), .svcoeff(svcoeff),
    .download(download), .busy(busy), .dvo(dvo), .regout(regout), .msb(msb)
`ifdef SLICE_MEM_MC_SAT_EN
    , .ovf(ovf)
`endif
  );

  slice_mem_mc #(
    .DWIDTH(8), .CWIDTH(9), .AWIDTH(18), .NCH(2),
    .BLOCKSIZE(2), .WINCOLS(2), .WPI(3)
  ) u_sat (
    .clk(clk), .reset_n(reset_n), .dvi(dvi2), .data(data2), .svcoeff(svcoeff2),
    .download(download2), .busy(busy2), .dvo(dvo2), .regout(regout2), .msb(msb2)
`ifdef SLICE_MEM_MC_SAT_EN
    , .ovf(ovf2)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] r;
    logic [1:0]  m;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model state: current window accumulation and a 3-deep recall buffer.
  int c0, c1;
  int m_acc0, m_acc1, m_pix, m_ptr;
  int m_lb0[3];
  int m_lb1[3];
  bit m_v[3];

  always @(negedge clk) begin
    if (reset_n && dvo) begin
      checks++;
      assert (sb_q.size() > 0) else begin
        errors++;
        $error("FAIL sb_unexpected_dvo observed=dvo regout=%h expected=no_dvo", regout);
      end
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        checks++;
        assert (regout === mon_e.r) else begin
          errors++;
          $error("FAIL sb_regout observed=%h expected=%h", regout, mon_e.r);
        end
        checks++;
        assert (msb === mon_e.m) else begin
          errors++;
          $error("FAIL sb_msb observed=%b expected=%b", msb, mon_e.m);
        end
      end
    end
  end

  task automatic model_clear();
    m_acc0 = 0; m_acc1 = 0; m_pix = 0; m_ptr = 0;
    for (int i = 0; i < 3; i++) begin
      m_lb0[i] = 0; m_lb1[i] = 0; m_v[i] = 1'b0;
    end
  endtask

  task automatic set_coeff(input int a, input int b);
    int ta, tb;
    ta = a; tb = b;
    c0 = a; c1 = b;
    svcoeff = {tb[8:0], ta[8:0]};
  endtask

  task automatic pix(input logic [7:0] d);
    int r0, r1;
    exp_t e;
    dvi = 1'b1; data = d; download = 1'b0;
    m_acc0 += c0 * int'(d);
    m_acc1 += c1 * int'(d);
    m_pix++;
    if (m_pix == 4) begin
      r0 = m_acc0 + (m_v[m_ptr] ? m_lb0[m_ptr] : 0);
      r1 = m_acc1 + (m_v[m_ptr] ? m_lb1[m_ptr] : 0);
      m_lb0[m_ptr] = r0; m_lb1[m_ptr] = r1; m_v[m_ptr] = 1'b1;
      m_ptr = (m_ptr + 1) % 3;
      e.r = {r1, r0};
      e.m = {r1 > 0, r0 > 0};
      sb_q.push_back(e);
      m_acc0 = 0; m_acc1 = 0; m_pix = 0;
    end
    @(posedge clk); #1;
    dvi = 1'b0;
  endtask

  task automatic bubble();
    dvi = 1'b0; data = 8'($urandom);
    @(posedge clk); #1;
    checks++;
    assert (dvo === 1'b0) else begin
      errors++;
      $error("FAIL bubble_dvo observed=%b expected=0", dvo);
    end
  endtask

  task automatic idle(input int n);
    dvi = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // The coincident pixel (data 99) must be dropped in favour of download.
  task automatic do_flush(input int hold, input int exp_busy);
    int n;
    n = 0;
    model_clear();
    download = 1'b1; dvi = 1'b1; data = 8'd99;
    repeat (hold) begin
      @(posedge clk); #1;
      if (busy) n++;
    end
    download = 1'b0; dvi = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (busy) n++;
    end
    checks++;
    assert (n == exp_busy) else begin
      errors++;
      $error("FAIL flush_busy_len observed=%0d expected=%0d", n, exp_busy);
    end
  endtask

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [35:0] e_sat;
    logic [1:0]  e_msb2;
    int          k;

    reset_n = 1'b0;
    dvi2 = 1'b0; data2 = '0; svcoeff2 = '0; download2 = 1'b0;
    c0 = 0; c1 = 0;
    model_clear();
    repeat (4) begin
      dvi = 1'($urandom); data = 8'($urandom); svcoeff = 18'($urandom);
      download = 1'($urandom); dvi2 = 1'($urandom); data2 = 8'($urandom);
      @(posedge clk); #1;
    end
    check64("rst_regout", regout, 64'd0);
    check64("rst_msb", {62'd0, msb}, 64'd0);
    check64("rst_dvo", {63'd0, dvo}, 64'd0);
    check64("rst_busy", {63'd0, busy}, 64'd0);
    check64("rst_regout_sat", {28'd0, regout2}, 64'd0);

    dvi = 1'b0; download = 1'b0; data = '0; dvi2 = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single window
    set_coeff(3, -2);
    repeat (5) pix(8'd10);
    idle(3);
    check64("single_hold", regout, {32'hFFFF_FFB0, 32'd120});
    check64("single_msb", {62'd0, msb}, 64'd1);
    do_flush(1, 3);

    // Line recall
    repeat (29) pix(8'd10);
    idle(3);
    check64("recall_hold", regout, {32'hFFFF_FF10, 32'd360});
    do_flush(2, 4);

    // Bubbles between every pixel
    repeat (29) begin pix(8'd10); bubble(); end
    idle(2);
    check64("bubble_hold", regout, {32'hFFFF_FF10, 32'd360});
    do_flush(1, 3);

    // Extreme coefficients with random pixels
    set_coeff(-256, 255);
    repeat (21) pix(8'($urandom_range(0, 255)));
    idle(3);
    do_flush(1, 3);

    // Flush mid-window: partial window lost, no recall afterwards
    set_coeff(3, -2);
    repeat (6) pix(8'd10);
    idle(2);
    do_flush(1, 3);
    check64("flush_clr_regout", regout, 64'd0);
    check64("flush_clr_msb", {62'd0, msb}, 64'd0);
    repeat (5) pix(8'd10);
    idle(3);
    check64("flush_norecall", regout, {32'hFFFF_FFB0, 32'd120});

    // Reset in the middle of a flush leaves the buffer reading as zero
    do_flush(1, 3);
    repeat (13) pix(8'd10);
    idle(2);
    download = 1'b1;
    @(posedge clk); #1;
    download = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    check64("rst_midflush_busy", {63'd0, busy}, 64'd0);
    check64("rst_midflush_regout", regout, 64'd0);
    reset_n = 1'b1;
    model_clear();
    @(posedge clk); #1;
    repeat (17) pix(8'd10);
    idle(3);
    check64("rst_midflush_recall", regout, {32'hFFFF_FF60, 32'd240});

    // 18-bit instance: 4 x (+/-255 * 255) exceeds the range
    svcoeff2 = {9'h101, 9'h0FF};
    data2 = 8'd255;
    repeat (5) begin
      dvi2 = 1'b1;
      @(posedge clk); #1;
    end
    dvi2 = 1'b0;
    k = 0;
    while (!dvo2 && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    check64("sat_dvo", {63'd0, dvo2}, 64'd1);
`ifdef SLICE_MEM_MC_SAT_EN
    e_sat  = {18'h20000, 18'h1FFFF};
    e_msb2 = 2'b01;
    check64("sat_ovf", {62'd0, ovf2}, 64'd3);
`else
    e_sat  = {18'd2044, 18'h3F804};
    e_msb2 = 2'b10;
`endif
    check64("sat_regout", {28'd0, regout2}, {28'd0, e_sat});
    check64("sat_msb", {62'd0, msb2}, {62'd0, e_msb2});

    idle(3);
    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
